// File: rtl/pkt_stream_arbiter_pkg.sv
// pkt_arb_pkg: state encodings, default widths and the round-robin pick helper
package pkt_arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, XFER = 2'd1, DRAIN = 2'd2} state_t;
  localparam int BUS_SIZE_DEF = 16;
  localparam int WORD_SIZE_DEF = 4;
  localparam int NUM_REQ_DEF = 4;
  localparam int BURST_MAX_DEF = 8;
  localparam int ERR_CNT_W_DEF = 8;
  localparam int MAX_REQ_W = 5;
  localparam int MAX_REQ = 1 << MAX_REQ_W;
  function automatic int rr_pick(input logic [MAX_REQ-1:0] req, input int ptr, input int n);
    int pick;
    int j;
    logic found;
    pick = 0;
    found = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      j = (ptr + k >= n) ? ptr + k - n : ptr + k;
      if (k < n && !found && req[MAX_REQ_W'(j)]) begin
        pick = j;
        found = 1'b1;
      end
    end
    return pick;
  endfunction
endpackage

// File: rtl/pkt_stream_arbiter_if.sv
// pkt_stream_arbiter_if: source, checker and status signals of the packet arbiter
interface pkt_stream_arbiter_if import pkt_arb_pkg::*; #(
  parameter int BUS_SIZE = BUS_SIZE_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF,
  parameter int IDX_W = $clog2(NUM_REQ)
) ();
  logic [NUM_REQ-1:0] req_valid;
  logic [NUM_REQ*BUS_SIZE-1:0] req_data;
  logic [NUM_REQ-1:0] req_last;
  logic [NUM_REQ-1:0] req_ready;
  logic [BUS_SIZE-1:0] chk_data;
  logic chk_valid;
  logic chk_error;
  logic [NUM_REQ-1:0] grant;
  logic busy;
  logic [IDX_W-1:0] err_src;
  logic [ERR_CNT_W-1:0] err_count;
  modport master (
    input req_valid, req_data, req_last, chk_error,
    output req_ready, chk_data, chk_valid, grant, busy, err_src, err_count
  );
  modport slave (
    output req_valid, req_data, req_last, chk_error,
    input req_ready, chk_data, chk_valid, grant, busy, err_src, err_count
  );
endinterface

// File: rtl/pkt_stream_arbiter_rr_pick.sv
// rr_pick_onehot: first requester at or after the pointer, as index and one-hot
module rr_pick_onehot import pkt_arb_pkg::*; #(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);
  logic [MAX_REQ-1:0] req_ext;
  assign req_ext = MAX_REQ'(req_i);
  assign idx_o = IDX_W'(rr_pick(req_ext, int'(ptr_i), NUM_REQ));
  assign any_o = |req_i;
  assign onehot_o = any_o ? NUM_REQ'(1) << idx_o : '0;
endmodule

// File: rtl/pkt_stream_arbiter.sv
// pkt_stream_arbiter: round-robin packet arbiter feeding the packet checker, with error drain
module pkt_stream_arbiter import pkt_arb_pkg::*; #(
  parameter int BUS_SIZE = BUS_SIZE_DEF,
  parameter int WORD_SIZE = WORD_SIZE_DEF,
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF,
  parameter int ERR_CNT_W = ERR_CNT_W_DEF,
  parameter int IDX_W = $clog2(NUM_REQ)
) (
  input logic clk,
  input logic reset,
  pkt_stream_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(BURST_MAX);
  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || BURST_MAX < 2 || BUS_SIZE % WORD_SIZE != 0) begin : g_bad_cfg
    $error("pkt_stream_arbiter: unsupported parameter combination");
  end
  state_t state_q;
  logic [NUM_REQ-1:0] grant_q, pick_oh;
  logic [IDX_W-1:0] rr_ptr_q, owner_q, err_src_q, pick_idx, next_ptr;
  logic [CNT_W-1:0] word_cnt_q;
  logic [BUS_SIZE-1:0] chk_data_q;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic chk_valid_q, pick_any, acc, last_acc, burst_end, release_pkt;
  rr_pick_onehot #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i(bus.req_valid),
    .ptr_i(rr_ptr_q),
    .onehot_o(pick_oh),
    .idx_o(pick_idx),
    .any_o(pick_any)
  );
  // owner_q is only meaningful outside IDLE; the error path overrides the burst limit
  always_comb begin
    acc = state_q != IDLE && bus.req_valid[owner_q];
    last_acc = acc && bus.req_last[owner_q];
    burst_end = acc && (bus.req_last[owner_q] || word_cnt_q == CNT_W'(BURST_MAX - 1));
    release_pkt = state_q == XFER ? (bus.chk_error ? last_acc : burst_end) : state_q == DRAIN && last_acc;
    next_ptr = owner_q == IDX_W'(NUM_REQ - 1) ? '0 : owner_q + 1'b1;
    err_count_d = &err_count_q ? err_count_q : err_count_q + 1'b1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_ptr_q <= '0;
      owner_q <= '0;
      word_cnt_q <= '0;
      chk_data_q <= '0;
      chk_valid_q <= 1'b0;
      err_src_q <= '0;
      err_count_q <= '0;
    end else begin
      chk_valid_q <= 1'b0;
      if (bus.chk_error) begin
        err_src_q <= owner_q;
        err_count_q <= err_count_d;
      end
      if (state_q == IDLE && pick_any) begin
        state_q <= XFER;
        grant_q <= pick_oh;
        owner_q <= pick_idx;
        word_cnt_q <= '0;
      end
      if (state_q == XFER && acc) begin
        chk_data_q <= bus.req_data[owner_q*BUS_SIZE +: BUS_SIZE];
        chk_valid_q <= !bus.chk_error;
        word_cnt_q <= word_cnt_q + 1'b1;
      end
      if (state_q == XFER && bus.chk_error && !last_acc) state_q <= DRAIN;
      if (release_pkt) begin
        state_q <= IDLE;
        grant_q <= '0;
        rr_ptr_q <= next_ptr;
      end
    end
  end
  assign bus.req_ready = grant_q;
  assign bus.grant = grant_q;
  assign bus.busy = state_q != IDLE;
  assign bus.chk_data = chk_data_q;
  assign bus.chk_valid = chk_valid_q;
  assign bus.err_src = err_src_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_pkt_stream_arbiter.sv
// tb_pkt_stream_arbiter: randomized phases checked against a packet-level reference model
module tb_pkt_stream_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int BMAX = 8;
  logic clk = 1'b0;
  logic reset;
  pkt_stream_arbiter_if #(.BUS_SIZE(W), .NUM_REQ(N), .ERR_CNT_W(8)) bus ();
  pkt_stream_arbiter #(.BUS_SIZE(W), .WORD_SIZE(4), .NUM_REQ(N), .BURST_MAX(BMAX), .ERR_CNT_W(8)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );
  always #5 clk = ~clk;
  int n_checks = 0;
  int n_fail = 0;
  bit m_busy, m_drain, m_valid;
  int m_owner, m_last_owner, m_ptr, m_words, m_err_src, m_err_cnt, acc_src;
  logic [W-1:0] m_data;
  int rem [N];
  logic [W-1:0] wrd [N];
  int p_valid, p_new, p_err, len_min, len_max;
  logic [N-1:0] gen_mask;
  bit force_err;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  // Reference: one owner at a time, words counted per grant, pointer moves past a released owner
  task automatic model_update();
    bit acc, fin, rel;
    int c;
    acc_src = -1;
    if (reset) begin
      m_busy = 0; m_drain = 0; m_owner = 0; m_last_owner = 0; m_ptr = 0;
      m_words = 0; m_data = '0; m_valid = 0; m_err_src = 0; m_err_cnt = 0;
      return;
    end
    m_valid = 0;
    rel = 0;
    if (bus.chk_error) begin
      m_err_src = m_last_owner;
      if (m_err_cnt < 255) m_err_cnt++;
    end
    if (!m_busy) begin
      for (int k = 0; k < N; k++) begin
        c = (m_ptr + k) % N;
        if (bus.req_valid[c]) begin
          m_busy = 1; m_owner = c; m_last_owner = c; m_drain = 0; m_words = 0;
          break;
        end
      end
    end else begin
      acc = bus.req_valid[m_owner];
      fin = acc && bus.req_last[m_owner];
      if (acc) acc_src = m_owner;
      if (!m_drain) begin
        if (acc) begin
          m_data = bus.req_data[m_owner*W +: W];
          m_valid = !bus.chk_error;
          m_words++;
        end
        if (bus.chk_error) begin
          if (fin) rel = 1;
          else m_drain = 1;
        end else if (acc && (fin || m_words == BMAX)) rel = 1;
      end else if (fin) rel = 1;
      if (rel) begin
        m_busy = 0;
        m_drain = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
  endtask
  task automatic compare();
    logic [N-1:0] exp_g;
    exp_g = m_busy ? N'(1 << m_owner) : '0;
    check("grant", bus.grant, exp_g);
    check("req_ready", bus.req_ready, exp_g);
    check("busy", bus.busy, m_busy);
    check("chk_valid", bus.chk_valid, m_valid);
    if (m_valid) check("chk_data", bus.chk_data, m_data);
    check("err_src", bus.err_src, m_err_src);
    check("err_count", bus.err_count, m_err_cnt);
  endtask
  task automatic drive_next();
    logic [N-1:0] vld, lst;
    logic [N*W-1:0] dat;
    for (int i = 0; i < N; i++) begin
      if (acc_src == i) begin
        rem[i]--;
        wrd[i] = W'($urandom);
      end
      if (rem[i] == 0 && gen_mask[i] && $urandom_range(99) < p_new) rem[i] = $urandom_range(len_max, len_min);
      vld[i] = rem[i] != 0 && $urandom_range(99) < p_valid;
      lst[i] = rem[i] == 1;
      dat[i*W +: W] = wrd[i];
    end
    bus.req_valid = vld;
    bus.req_last = lst;
    bus.req_data = dat;
    bus.chk_error = force_err || $urandom_range(99) < p_err;
  endtask
  task automatic redrive();
    acc_src = -1;
    drive_next();
  endtask
  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    compare();
    drive_next();
  endtask
  initial begin
    int n_valid;
    bit found;
    reset = 1'b1;
    acc_src = -1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      wrd[i] = W'($urandom);
    end
    p_valid = 100; p_new = 0; p_err = 0; len_min = 1; len_max = 1;
    gen_mask = '0; force_err = 0;
    drive_next();
    repeat (2) step();
    reset = 1'b0;
    rem[1] = 3;
    redrive();
    n_valid = 0;
    repeat (10) begin
      step();
      if (bus.chk_valid) n_valid++;
    end
    check("single_src_words", n_valid, 3);
    gen_mask = '1; p_new = 100;
    redrive();
    repeat (20) step();
    gen_mask = '0;
    repeat (10) step();
    rem[2] = 12;
    gen_mask = 4'b1011; p_new = 30; len_max = 3;
    redrive();
    repeat (60) step();
    gen_mask = '1; p_new = 50; p_valid = 80; len_max = 8; p_err = 10;
    redrive();
    repeat (300) step();
    force_err = 1;
    redrive();
    repeat (300) step();
    check("err_saturate", bus.err_count, 255);
    force_err = 0; p_err = 0; p_valid = 100; p_new = 100; len_min = 4;
    redrive();
    found = 0;
    for (int c = 0; c < 50 && !found; c++) begin
      step();
      found = m_busy && !m_drain;
    end
    check("mid_xfer_seen", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("post_reset_grant", bus.grant, 1);
    gen_mask = '1; len_min = 1; len_max = 12; p_valid = 70; p_new = 40; p_err = 3;
    redrive();
    repeat (2000) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
